// File: rtl/hrtf_fir_mac.sv
// hrtf_fir_mac: HRTF FIR multiply-accumulate engine.
// Keeps the last TAPS audio samples in a circular history buffer. While the
// delayed tap-stream qualifier is high, each coefficient arriving from BRAM is
// multiplied against the matching history sample and accumulated. At the end
// of a complete run one saturated, Q1.15-scaled sample is emitted.
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   sample_valid/in       new audio sample strobe and data (signed)
//   conv_en               tap-stream enable from the address generator
//   coef_data             signed coefficient (BRAM read data, COEF_LAT late)
//   out_sample            signed filtered sample, held between strobes
//   out_valid, out_sat    1-cycle result strobe and its clip flag
//   busy                  run in progress
//   tap_err, overrun      sticky error flags, cleared only by reset
module hrtf_fir_mac #(
    parameter int unsigned TAPS      = 128,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned COEF_FRAC = 15,
    parameter int unsigned COEF_LAT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              conv_en,
    input  logic [DATA_W-1:0] coef_data,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              out_sat,
    output logic              busy,
    output logic              tap_err,
    output logic              overrun
);

    localparam int unsigned PTR_W  = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam int unsigned PROD_W = 2 * DATA_W;

    localparam logic signed [ACC_W-1:0] SatMax =
        $signed({{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}});
    localparam logic signed [ACC_W-1:0] SatMin =
        $signed({{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}});

    typedef enum logic [1:0] {StIdle, StAccum, StDrain, StOutput} state_e;

    state_e state_q, state_d;

    logic signed [DATA_W-1:0] hist_q [TAPS];
    logic signed [DATA_W-1:0] hist_d [TAPS];
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]         base_q, base_d;
    logic [PTR_W-1:0]         tap_cnt_q, tap_cnt_d;
    logic [COEF_LAT-1:0]      q_dly_q, q_dly_d;
    logic                     q_prev_q, q_prev_d;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q, prod_vld_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0]        out_sample_q, out_sample_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_sat_q, out_sat_d;
    logic                     tap_err_q, tap_err_d;
    logic                     overrun_q, overrun_d;

    logic                     q, q_rise, consume;
    logic [PTR_W-1:0]         rd_base, rd_tap, rd_idx;
    logic [PTR_W:0]           rd_sum;
    logic [PROD_W-1:0]        coef_ext, x_ext;
    logic signed [ACC_W-1:0]  acc_shift;

    // q is conv_en re-timed to line up with the BRAM read data.
    assign q      = q_dly_q[COEF_LAT-1];
    assign q_rise = q & ~q_prev_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (q_rise) state_d = StAccum;
            StAccum: begin
                if (!q) begin
                    state_d = StIdle;
                end else if (tap_cnt_q == PTR_W'(TAPS - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain:  state_d = StOutput;
            StOutput: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != StIdle);
    end

    // History read address: x[n-k] = history[(base-1-k) mod TAPS]. The first
    // tap is taken in IDLE, before base_q holds the latched pointer.
    always_comb begin
        rd_base = (state_q == StIdle) ? wr_ptr_q : base_q;
        rd_tap  = (state_q == StIdle) ? '0 : tap_cnt_q;
        rd_sum  = {1'b0, rd_base} + (PTR_W + 1)'(TAPS - 1) - {1'b0, rd_tap};
        if (rd_sum >= (PTR_W + 1)'(TAPS)) begin
            rd_idx = PTR_W'(rd_sum - (PTR_W + 1)'(TAPS));
        end else begin
            rd_idx = PTR_W'(rd_sum);
        end
    end

    assign coef_ext  = {{DATA_W{coef_data[DATA_W-1]}}, coef_data};
    assign x_ext     = {{DATA_W{hist_q[rd_idx][DATA_W-1]}}, hist_q[rd_idx]};
    assign acc_shift = acc_q >>> COEF_FRAC;
    assign consume   = ((state_q == StIdle) && q_rise) || ((state_q == StAccum) && q);

    // Datapath next-state
    always_comb begin
        hist_d       = hist_q;
        wr_ptr_d     = wr_ptr_q;
        base_d       = base_q;
        tap_cnt_d    = tap_cnt_q;
        q_prev_d     = q;
        prod_d       = prod_q;
        prod_vld_d   = 1'b0;
        acc_d        = acc_q;
        out_sample_d = out_sample_q;
        out_valid_d  = 1'b0;
        out_sat_d    = 1'b0;
        tap_err_d    = tap_err_q;
        overrun_d    = overrun_q;

        q_dly_d    = q_dly_q << 1;
        q_dly_d[0] = conv_en;

        if (sample_valid) begin
            if (state_q == StIdle) begin
                hist_d[wr_ptr_q] = sample_in;
                wr_ptr_d = (wr_ptr_q == PTR_W'(TAPS - 1)) ? '0 : wr_ptr_q + 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // Product registered last cycle lands in the accumulator now.
        if (prod_vld_q && (state_q == StAccum || state_q == StDrain)) begin
            acc_d = acc_q + $signed({{(ACC_W - PROD_W){prod_q[PROD_W-1]}}, prod_q});
        end

        if (consume) begin
            prod_d     = $signed(coef_ext) * $signed(x_ext);
            prod_vld_d = 1'b1;
            if (state_q == StIdle) begin
                acc_d     = '0;
                base_d    = wr_ptr_q;
                tap_cnt_d = PTR_W'(1);
            end else begin
                tap_cnt_d = tap_cnt_q + 1'b1;
            end
        end

        // Short run, or q still high / rising again after a complete run.
        if ((state_q == StAccum && !q) ||
            ((state_q == StDrain || state_q == StOutput) && q)) begin
            tap_err_d = 1'b1;
        end

        if (state_q == StOutput) begin
            out_valid_d = 1'b1;
            if (acc_shift > SatMax) begin
                out_sample_d = SatMax[DATA_W-1:0];
                out_sat_d    = 1'b1;
            end else if (acc_shift < SatMin) begin
                out_sample_d = SatMin[DATA_W-1:0];
                out_sat_d    = 1'b1;
            end else begin
                out_sample_d = acc_shift[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(TAPS); i++) begin
                hist_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            base_q       <= '0;
            tap_cnt_q    <= '0;
            q_dly_q      <= '0;
            q_prev_q     <= 1'b0;
            prod_q       <= '0;
            prod_vld_q   <= 1'b0;
            acc_q        <= '0;
            out_sample_q <= '0;
            out_valid_q  <= 1'b0;
            out_sat_q    <= 1'b0;
            tap_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            tap_cnt_q    <= tap_cnt_d;
            q_dly_q      <= q_dly_d;
            q_prev_q     <= q_prev_d;
            prod_q       <= prod_d;
            prod_vld_q   <= prod_vld_d;
            acc_q        <= acc_d;
            out_sample_q <= out_sample_d;
            out_valid_q  <= out_valid_d;
            out_sat_q    <= out_sat_d;
            tap_err_q    <= tap_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_valid  = out_valid_q;
    assign out_sat    = out_sat_q;
    assign tap_err    = tap_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_hrtf_fir_mac.sv
// Testbench for hrtf_fir_mac: directed runs with a reference convolution model,
// expected results queued at stimulus time and popped when out_valid strobes.
module tb_hrtf_fir_mac;

    localparam int TAPS = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_in = '0;
    logic        conv_en = 1'b0;
    logic [15:0] coef_data = '0;
    logic [15:0] out_sample;
    logic        out_valid, out_sat, busy, tap_err, overrun;

    always #5 clk = ~clk;

    hrtf_fir_mac dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .conv_en      (conv_en),
        .coef_data    (coef_data),
        .out_sample   (out_sample),
        .out_valid    (out_valid),
        .out_sat      (out_sat),
        .busy         (busy),
        .tap_err      (tap_err),
        .overrun      (overrun)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int strobes = 0;

    logic [16:0]        sb_q [$];   // {sat, sample}
    logic signed [15:0] m_hist [TAPS];
    int                 m_wr;
    logic signed [15:0] h_tb [TAPS];
    logic [16:0]        last_exp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: direct convolution over the model history, Q1.15 scale, clip.
    function automatic logic [16:0] model_out();
        longint acc = 0;
        longint sh;
        for (int k = 0; k < TAPS; k++) begin
            int idx = (m_wr + TAPS - 1 - k) % TAPS;
            acc += longint'(h_tb[k]) * longint'(m_hist[idx]);
        end
        sh = acc >>> 15;
        if (sh > 32767) return {1'b1, 16'h7FFF};
        if (sh < -32768) return {1'b1, 16'h8000};
        return {1'b0, sh[15:0]};
    endfunction

    // Scoreboard consumer
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            strobes++;
            n_cmp++;
            assert (sb_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_strobe: observed out_valid=1 expected none pending");
            end
            if (sb_q.size() != 0) begin
                logic [16:0] e;
                e = sb_q.pop_front();
                chk("out_result", {15'd0, out_sat, out_sample}, {15'd0, e});
            end
        end
    end

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        conv_en = 1'b0;
        sample_valid = 1'b0;
        coef_data = '0;
        repeat (cycles) tick();
        reset = 1'b0;
        for (int i = 0; i < TAPS; i++) m_hist[i] = '0;
        m_wr = 0;
    endtask

    task automatic write_sample(input logic [15:0] v);
        sample_valid = 1'b1;
        sample_in = v;
        tick();
        sample_valid = 1'b0;
        m_hist[m_wr] = v;
        m_wr = (m_wr + 1) % TAPS;
    endtask

    task automatic clear_h();
        for (int i = 0; i < TAPS; i++) h_tb[i] = '0;
    endtask

    // Drives conv_en for n cycles, with coefficients arriving two cycles later
    // like BRAM read data. sv_iter >= 0 injects a sample strobe mid-run.
    task automatic run_conv(input int n, input int sv_iter, input logic [15:0] sv_val,
                            input string tag);
        int iters;
        int seen;
        int seen_at;
        iters = ((n > TAPS) ? n : TAPS) + 8;
        seen = 0;
        seen_at = -1;
        if (n >= TAPS) begin
            last_exp = model_out();
            sb_q.push_back(last_exp);
        end
        for (int i = 0; i < iters; i++) begin
            conv_en = (i < n);
            coef_data = '0;
            if (i >= 2 && (i - 2) < TAPS && (i - 2) < n) coef_data = h_tb[i-2];
            sample_valid = (i == sv_iter);
            sample_in = sv_val;
            tick();
            if (out_valid === 1'b1) begin
                seen++;
                if (seen_at < 0) seen_at = i + 1;
            end
        end
        conv_en = 1'b0;
        sample_valid = 1'b0;
        coef_data = '0;
        if (n >= TAPS) begin
            chk({tag, "_strobes"}, seen, 1);
            chk({tag, "_latency"}, seen_at, TAPS + 4);
            chk({tag, "_hold"}, {15'd0, out_sat, out_sample}, {15'd0, 1'b0, last_exp[15:0]});
        end else begin
            chk({tag, "_no_strobe"}, seen, 0);
        end
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int s0;
        do_reset(3);
        chk("rst_out_sample", out_sample, 0);
        chk("rst_flags", {out_valid, out_sat, busy, tap_err, overrun}, 0);

        // Impulse
        write_sample(16'h4000);
        clear_h();
        h_tb[0] = 16'sh4000;
        run_conv(TAPS, -1, 16'h0, "impulse");
        chk("impulse_value", out_sample, 16'h2000);

        // Reset held 3 cycles in the middle of a run
        conv_en = 1'b1;
        repeat (12) tick();
        chk("midrun_busy", busy, 1);
        s0 = strobes;
        do_reset(3);
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_out", {out_sample, out_valid, out_sat, tap_err}, 0);
        repeat (140) tick();
        chk("midrun_no_strobe", strobes, s0);

        // Delay: tap 5 picks the sample written five writes ago
        write_sample(16'h1000);
        repeat (5) write_sample(16'h0000);
        clear_h();
        h_tb[5] = 16'sh7FFF;
        run_conv(TAPS, -1, 16'h0, "delay");
        chk("delay_value", out_sample, 16'h0FFF);

        // Positive and negative saturation
        for (int i = 0; i < TAPS; i++) write_sample(16'h7FFF);
        for (int i = 0; i < TAPS; i++) h_tb[i] = 16'sh7FFF;
        run_conv(TAPS, -1, 16'h0, "sat_pos");
        chk("sat_pos_value", {out_sample, 16'h0}, {16'h7FFF, 16'h0});
        for (int i = 0; i < TAPS; i++) write_sample(16'h8000);
        run_conv(TAPS, -1, 16'h0, "sat_neg");
        chk("sat_neg_value", out_sample, 16'h8000);

        // conv_en held past TAPS: result still correct, tap_err raised
        do_reset(2);
        for (int i = 0; i < 8; i++) write_sample(16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < TAPS; i++) h_tb[i] = 16'($urandom_range(0, 16'hFFFF));
        run_conv(TAPS + 3, -1, 16'h0, "long_run");
        chk("long_run_tap_err", tap_err, 1);
        do_reset(2);
        chk("rst_clears_tap_err", tap_err, 0);

        // Short run, then a good run with tap_err sticky
        for (int i = 0; i < TAPS; i++) write_sample(16'($urandom_range(0, 16'hFFFF)));
        for (int i = 0; i < TAPS; i++) h_tb[i] = 16'($urandom_range(0, 16'hFFFF));
        run_conv(100, -1, 16'h0, "short_run");
        chk("short_run_tap_err", tap_err, 1);
        run_conv(TAPS, -1, 16'h0, "after_short");
        chk("after_short_tap_err", tap_err, 1);
        chk("no_overrun_yet", overrun, 0);

        // Sample strobe while busy is dropped
        for (int i = 0; i < TAPS; i++) h_tb[i] = 16'($urandom_range(0, 16'h3FFF));
        run_conv(TAPS, -1, 16'h0, "ovr_ref");
        run_conv(TAPS, 40, 16'h1234, "ovr_strobe");
        chk("overrun_set", overrun, 1);
        run_conv(TAPS, -1, 16'h0, "ovr_after");

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
